// File: rtl/prtc_host_seq.sv
// Host-side sequencer and bus arbiter for the PRTC register pair (C033 DATA / C034 CTL).
// The CPU owns the PRTC bus by default. After a quiet window with no CPU PRTC access, a
// pending host PRAM request takes the bus and is expanded into the six-step extended-PRAM
// protocol while the CPU is held off through cpu_ready.
module prtc_host_seq #(
    parameter int QUIET = 64
) (
    input  logic       CLK_14M,
    input  logic       reset,
    input  logic       cen,
    input  logic       cpu_strobe,
    input  logic       cpu_addr,
    input  logic       cpu_rw,
    input  logic [7:0] cpu_din,
    output logic [7:0] cpu_dout,
    output logic       cpu_ready,
    input  logic       host_req,
    input  logic       host_we,
    input  logic [7:0] host_addr,
    input  logic [7:0] host_wdata,
    output logic       host_ack,
    output logic [7:0] host_rdata,
    output logic       p_strobe,
    output logic       p_addr,
    output logic       p_rw,
    output logic [7:0] p_din,
    input  logic [7:0] p_dout
);

    localparam int CW = (QUIET < 1) ? 1 : $clog2(QUIET + 1);
    localparam logic [CW-1:0] QUIET_MAX = CW'(QUIET);

    typedef enum logic [2:0] {
        ST_CPU,
        ST_S1,
        ST_S2,
        ST_S3,
        ST_S4,
        ST_S5,
        ST_S6,
        ST_DONE
    } state_t;

    state_t        state_q;
    logic [CW-1:0] quiet_q;
    logic          opWe_q;
    logic [7:0]    opAddr_q;
    logic [7:0]    opWdata_q;
    logic [7:0]    rdata_q;

    logic          cpuOwner;
    logic          stepAddr;
    logic          stepRw;
    logic [7:0]    stepDin;

    // Arbitration and step sequencing; host operands are latched at grant so the
    // whole sequence uses one consistent request even if the host lets go early.
    always_ff @(posedge CLK_14M or posedge reset) begin
        if (reset) begin
            state_q   <= ST_CPU;
            quiet_q   <= '0;
            opWe_q    <= 1'b0;
            opAddr_q  <= 8'h00;
            opWdata_q <= 8'h00;
            rdata_q   <= 8'h00;
        end else begin
            case (state_q)
                ST_CPU: begin
                    if (cpu_strobe) begin
                        quiet_q <= '0;
                    end else if (cen) begin
                        if (quiet_q == QUIET_MAX) begin
                            if (host_req) begin
                                state_q   <= ST_S1;
                                opWe_q    <= host_we;
                                opAddr_q  <= host_addr;
                                opWdata_q <= host_wdata;
                            end
                        end else begin
                            quiet_q <= quiet_q + CW'(1);
                        end
                    end
                end
                ST_S1: if (cen) state_q <= ST_S2;
                ST_S2: if (cen) state_q <= ST_S3;
                ST_S3: if (cen) state_q <= ST_S4;
                ST_S4: if (cen) state_q <= ST_S5;
                ST_S5: if (cen) state_q <= ST_S6;
                ST_S6: begin
                    if (cen) begin
                        if (!opWe_q) begin
                            rdata_q <= p_dout;
                        end
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    quiet_q <= '0;
                    state_q <= ST_CPU;
                end
                default: state_q <= ST_CPU;
            endcase
        end
    end

    // Bus values for the current host step; address/rw default to the harmless C034 read.
    always_comb begin
        stepAddr = 1'b1;
        stepRw   = 1'b1;
        stepDin  = 8'h00;
        case (state_q)
            ST_S1: begin
                stepAddr = 1'b0;
                stepRw   = 1'b0;
                stepDin  = {~opWe_q, 4'b0111, opAddr_q[7:5]};
            end
            ST_S2, ST_S4: begin
                stepAddr = 1'b1;
                stepRw   = 1'b0;
                stepDin  = 8'h80;
            end
            ST_S3: begin
                stepAddr = 1'b0;
                stepRw   = 1'b0;
                stepDin  = {1'b0, opAddr_q[4:0], 2'b00};
            end
            ST_S5: begin
                stepAddr = opWe_q ? 1'b0 : 1'b1;
                stepRw   = 1'b0;
                stepDin  = opWe_q ? opWdata_q : 8'hC0;
            end
            ST_S6: begin
                stepAddr = opWe_q ? 1'b1 : 1'b0;
                stepRw   = opWe_q ? 1'b0 : 1'b1;
                stepDin  = opWe_q ? 8'h80 : 8'h00;
            end
            default: begin
                stepAddr = 1'b1;
                stepRw   = 1'b1;
                stepDin  = 8'h00;
            end
        endcase
    end

    assign cpuOwner   = (state_q == ST_CPU) || (state_q == ST_DONE);
    assign cpu_ready  = cpuOwner;
    assign cpu_dout   = p_dout;
    assign host_ack   = (state_q == ST_DONE);
    assign host_rdata = rdata_q;

    // PRTC bus mux: CPU passthrough, a host step only on cen, otherwise the idle drive,
    // so DATA is never left addressed for write outside a real write step.
    always_comb begin
        p_strobe = 1'b0;
        p_addr   = 1'b1;
        p_rw     = 1'b1;
        p_din    = 8'h00;
        if (reset) begin
            p_strobe = 1'b0;
            p_addr   = 1'b1;
            p_rw     = 1'b1;
            p_din    = 8'h00;
        end else if (cpuOwner) begin
            p_strobe = cpu_strobe & cpu_ready;
            p_addr   = cpu_addr;
            p_rw     = cpu_rw;
            p_din    = cpu_din;
        end else if (cen) begin
            p_strobe = 1'b1;
            p_addr   = stepAddr;
            p_rw     = stepRw;
            p_din    = stepDin;
        end
    end

endmodule

// File: tb/tb_prtc_host_seq.sv
// Directed testbench for prtc_host_seq with QUIET=4: host write/read expansion,
// CPU holdoff and grant timing, CPU stall during a host op, cen gaps and mid-op reset.
module tb_prtc_host_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       cen;
    logic       cpuStrobe;
    logic       cpuAddr;
    logic       cpuRw;
    logic [7:0] cpuDin;
    logic [7:0] cpuDout;
    logic       cpuReady;
    logic       hostReq;
    logic       hostWe;
    logic [7:0] hostAddr;
    logic [7:0] hostWdata;
    logic       hostAck;
    logic [7:0] hostRdata;
    logic       pStrobe;
    logic       pAddr;
    logic       pRw;
    logic [7:0] pDin;
    logic [7:0] pDout;

    int assertCount = 0;
    int failCount   = 0;
    int cyc         = 0;
    int cenPeriod   = 1;
    int cenPhase    = 0;
    int badStrobe   = 0;
    logic [9:0] strobeQ[$];
    logic [9:0] expQ[6];

    prtc_host_seq #(.QUIET(4)) dut (
        .CLK_14M   (clk),
        .reset     (reset),
        .cen       (cen),
        .cpu_strobe(cpuStrobe),
        .cpu_addr  (cpuAddr),
        .cpu_rw    (cpuRw),
        .cpu_din   (cpuDin),
        .cpu_dout  (cpuDout),
        .cpu_ready (cpuReady),
        .host_req  (hostReq),
        .host_we   (hostWe),
        .host_addr (hostAddr),
        .host_wdata(hostWdata),
        .host_ack  (hostAck),
        .host_rdata(hostRdata),
        .p_strobe  (pStrobe),
        .p_addr    (pAddr),
        .p_rw      (pRw),
        .p_din     (pDin),
        .p_dout    (pDout)
    );

    // 14M clock
    always #5 clk = ~clk;

    // PRTC read response: stored byte 0x5A on a DATA read, a distinct filler otherwise
    assign pDout = (!pAddr && pRw) ? 8'h5A : 8'hEE;

    // Log every PRTC strobe and flag any that lands on a cen=0 cycle
    always @(negedge clk) begin
        if (pStrobe === 1'b1) begin
            strobeQ.push_back({pAddr, pRw, pDin});
            if (!cen) badStrobe++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one clock, update cen pattern, drop the one-cycle CPU strobe, let outputs settle
    task automatic stepClock();
        @(posedge clk);
        #1;
        cyc++;
        cenPhase  = (cenPhase + 1) % cenPeriod;
        cen       = (cenPhase == 0);
        cpuStrobe = 1'b0;
        #1;
    endtask

    function automatic logic [9:0] ent(input logic a, input logic rw, input logic [7:0] d);
        return {a, rw, d};
    endfunction

    task automatic checkStrobes(input string tag, input bit readOp);
        logic [9:0] obs;
        checkOutput({tag, " strobe count"}, strobeQ.size(), 6);
        for (int i = 0; i < 6; i++) begin
            obs = (i < strobeQ.size()) ? strobeQ[i] : 10'h3FF;
            if (readOp && i == 5)
                checkOutput($sformatf("%s step%0d addr/rw", tag, i + 1), obs[9:8], expQ[i][9:8]);
            else
                checkOutput($sformatf("%s step%0d", tag, i + 1), obs, expQ[i]);
        end
    endtask

    // Hold a host request until ack; optionally inject a CPU strobe or a reset some steps after grant
    task automatic applyStimulus(input string tag, input bit we, input logic [7:0] addr,
                                 input logic [7:0] wdata, input int stallAt, input int resetAt,
                                 input logic [7:0] stallDin, output int fallCyc, output int ackCyc);
        bit didReset = 1'b0;
        fallCyc   = -1;
        ackCyc    = -1;
        hostWe    = we;
        hostAddr  = addr;
        hostWdata = wdata;
        hostReq   = 1'b1;
        strobeQ.delete();
        for (int n = 0; n < 400; n++) begin
            stepClock();
            if (!cpuReady && fallCyc < 0) fallCyc = cyc;
            if (stallAt >= 0 && fallCyc >= 0 && cyc == fallCyc + stallAt) begin
                cpuStrobe = 1'b1;
                cpuAddr   = 1'b0;
                cpuRw     = 1'b0;
                cpuDin    = 8'hFF;
                #1;
                checkOutput({tag, " stall p_strobe"}, pStrobe, 1'b1);
                checkOutput({tag, " stall p_din"}, pDin, stallDin);
                checkOutput({tag, " stall cpu_ready"}, cpuReady, 1'b0);
            end
            if (!didReset && resetAt >= 0 && fallCyc >= 0 && cyc == fallCyc + resetAt) begin
                didReset = 1'b1;
                reset = 1'b1;
                #1;
                checkOutput({tag, " rst p_strobe"}, pStrobe, 1'b0);
                checkOutput({tag, " rst p_addr"}, pAddr, 1'b1);
                checkOutput({tag, " rst p_rw"}, pRw, 1'b1);
                checkOutput({tag, " rst cpu_ready"}, cpuReady, 1'b1);
                checkOutput({tag, " rst host_ack"}, hostAck, 1'b0);
                checkOutput({tag, " rst host_rdata"}, hostRdata, 8'h00);
                stepClock();
                checkOutput({tag, " rst held host_ack"}, hostAck, 1'b0);
                reset = 1'b0;
                strobeQ.delete();
                fallCyc = -1;
            end
            if (hostAck) begin
                ackCyc  = cyc;
                hostReq = 1'b0;
                break;
            end
        end
        if (ackCyc < 0) begin
            hostReq = 1'b0;
            checkOutput({tag, " ack timeout"}, 0, 1);
        end
    endtask

    initial begin
        int fallCyc;
        int ackCyc;
        int lastStrobe;
        bit readyDropped;

        // Reset with the CPU inputs set to a DATA write: outputs must still show reset values
        reset     = 1'b1;
        cen       = 1'b1;
        cpuStrobe = 1'b1;
        cpuAddr   = 1'b0;
        cpuRw     = 1'b0;
        cpuDin    = 8'hAA;
        hostReq   = 1'b0;
        hostWe    = 1'b0;
        hostAddr  = 8'h00;
        hostWdata = 8'h00;
        #12;
        checkOutput("reset cpu_ready", cpuReady, 1'b1);
        checkOutput("reset host_ack", hostAck, 1'b0);
        checkOutput("reset host_rdata", hostRdata, 8'h00);
        checkOutput("reset p_strobe", pStrobe, 1'b0);
        checkOutput("reset p_addr", pAddr, 1'b1);
        checkOutput("reset p_rw", pRw, 1'b1);
        checkOutput("reset p_din", pDin, 8'h00);
        cpuStrobe = 1'b0;
        cpuAddr   = 1'b1;
        cpuRw     = 1'b1;
        cpuDin    = 8'h00;
        @(negedge clk);
        reset = 1'b0;

        // Host write 0x5A to 0xA7, cen every clock
        applyStimulus("write", 1'b1, 8'hA7, 8'h5A, -1, -1, 8'h00, fallCyc, ackCyc);
        expQ[0] = ent(1'b0, 1'b0, 8'h3D);
        expQ[1] = ent(1'b1, 1'b0, 8'h80);
        expQ[2] = ent(1'b0, 1'b0, 8'h1C);
        expQ[3] = ent(1'b1, 1'b0, 8'h80);
        expQ[4] = ent(1'b0, 1'b0, 8'h5A);
        expQ[5] = ent(1'b1, 1'b0, 8'h80);
        checkStrobes("write", 1'b0);
        checkOutput("write ack after ready fall", ackCyc - fallCyc, 6);
        checkOutput("write ack cpu_ready", cpuReady, 1'b1);
        stepClock();
        checkOutput("write ack one clock", hostAck, 1'b0);

        // Host read of 0xA7
        applyStimulus("read", 1'b0, 8'hA7, 8'h00, -1, -1, 8'h00, fallCyc, ackCyc);
        expQ[0] = ent(1'b0, 1'b0, 8'hBD);
        expQ[1] = ent(1'b1, 1'b0, 8'h80);
        expQ[2] = ent(1'b0, 1'b0, 8'h1C);
        expQ[3] = ent(1'b1, 1'b0, 8'h80);
        expQ[4] = ent(1'b1, 1'b0, 8'hC0);
        expQ[5] = ent(1'b0, 1'b1, 8'h00);
        checkStrobes("read", 1'b1);
        checkOutput("read host_rdata", hostRdata, 8'h5A);
        stepClock();

        // CPU strobes every 3rd cen cycle keep the host locked out
        hostReq      = 1'b1;
        hostWe       = 1'b0;
        hostAddr     = 8'h12;
        readyDropped = 1'b0;
        lastStrobe   = 0;
        for (int i = 0; i < 12; i++) begin
            stepClock();
            if (i % 3 == 0) begin
                cpuStrobe  = 1'b1;
                cpuAddr    = 1'b1;
                cpuRw      = 1'b1;
                lastStrobe = cyc;
            end
            #1;
            if (i == 0) checkOutput("holdoff passthrough strobe", {pStrobe, pAddr, pRw}, 3'b111);
            if (!cpuReady) readyDropped = 1'b1;
        end
        checkOutput("holdoff cpu_ready stays", readyDropped, 1'b0);

        // Strobes stop: grant after 4 quiet cen cycles; CPU write during S3 is stalled
        applyStimulus("stall", 1'b0, 8'h12, 8'h00, 2, -1, 8'h48, fallCyc, ackCyc);
        checkOutput("holdoff quiet cycles", fallCyc - 1 - lastStrobe - 1, 4);
        expQ[0] = ent(1'b0, 1'b0, 8'hB8);
        expQ[1] = ent(1'b1, 1'b0, 8'h80);
        expQ[2] = ent(1'b0, 1'b0, 8'h48);
        expQ[3] = ent(1'b1, 1'b0, 8'h80);
        expQ[4] = ent(1'b1, 1'b0, 8'hC0);
        expQ[5] = ent(1'b0, 1'b1, 8'h00);
        checkStrobes("stall", 1'b1);
        checkOutput("stall host_rdata", hostRdata, 8'h5A);
        stepClock();
        cpuStrobe = 1'b1;
        cpuAddr   = 1'b0;
        cpuRw     = 1'b0;
        cpuDin    = 8'hFF;
        #1;
        checkOutput("repeat forwarded", {pStrobe, pAddr, pRw, pDin}, {3'b100, 8'hFF});
        checkOutput("repeat cpu_ready", cpuReady, 1'b1);
        stepClock();
        cpuAddr = 1'b1;
        cpuRw   = 1'b1;
        cpuDin  = 8'h00;

        // Reset during S4, then the held request completes from scratch
        applyStimulus("reset", 1'b1, 8'h55, 8'h11, -1, 3, 8'h00, fallCyc, ackCyc);
        expQ[0] = ent(1'b0, 1'b0, 8'h3A);
        expQ[1] = ent(1'b1, 1'b0, 8'h80);
        expQ[2] = ent(1'b0, 1'b0, 8'h54);
        expQ[3] = ent(1'b1, 1'b0, 8'h80);
        expQ[4] = ent(1'b0, 1'b0, 8'h11);
        expQ[5] = ent(1'b1, 1'b0, 8'h80);
        checkStrobes("after reset", 1'b0);
        stepClock();

        // cen every 4th clock: six steps, ack 24 clocks after cpu_ready falls
        cenPeriod = 4;
        cenPhase  = 0;
        badStrobe = 0;
        applyStimulus("cen gap", 1'b1, 8'h3C, 8'hC3, -1, -1, 8'h00, fallCyc, ackCyc);
        expQ[0] = ent(1'b0, 1'b0, 8'h39);
        expQ[1] = ent(1'b1, 1'b0, 8'h80);
        expQ[2] = ent(1'b0, 1'b0, 8'h70);
        expQ[3] = ent(1'b1, 1'b0, 8'h80);
        expQ[4] = ent(1'b0, 1'b0, 8'hC3);
        expQ[5] = ent(1'b1, 1'b0, 8'h80);
        checkStrobes("cen gap", 1'b0);
        checkOutput("cen gap ack delay", ackCyc - fallCyc, 24);
        checkOutput("cen gap strobe on cen=0", badStrobe, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
